// File: rtl/karatsuba_booth_mult.sv
// Pipelined unsigned LOGQ x LOGQ multiplier: one Karatsuba level over three radix-4 Booth
// half-width products. Input register, split/add, Booth products, recombine; latency 3.
module karatsuba_booth_mult #(
    parameter int unsigned LOGQ = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LOGQ-1:0]     in_a,
    input  logic [LOGQ-1:0]     in_b,
    output logic [2*LOGQ-1:0]   out_c
);

    localparam int unsigned H  = LOGQ / 2;
    localparam int unsigned PW = 2 * H + 2;
    // Booth digit count: multiplier zero-extended by at least one MSB and padded to even width.
    localparam int unsigned ND = (H + 1) / 2 + 1;
    localparam int unsigned BW = 2 * ND;

    function automatic logic [PW-1:0] booth_mul(input logic [H:0] x, input logic [H:0] y);
        logic [BW:0]   w_y;
        logic [PW-1:0] w_x;
        logic [PW-1:0] w_pp;
        logic [PW-1:0] w_acc;
        w_y        = '0;
        w_y[H+1:1] = y;
        w_x        = PW'(x);
        w_acc      = '0;
        for (int i = 0; i < int'(ND); i++) begin
            case (w_y[2*i+2 -: 3])
                3'b001, 3'b010: w_pp = w_x;
                3'b011:         w_pp = w_x << 1;
                3'b100:         w_pp = ~(w_x << 1) + PW'(1);
                3'b101, 3'b110: w_pp = ~w_x + PW'(1);
                default:        w_pp = '0;
            endcase
            // Modular accumulation; negative digits arrive two's-complement sign-extended.
            w_acc = w_acc + (w_pp << (2 * i));
        end
        return w_acc;
    endfunction

    logic [LOGQ-1:0]   r_a;
    logic [LOGQ-1:0]   r_b;
    logic [H-1:0]      r_al;
    logic [H-1:0]      r_ah;
    logic [H-1:0]      r_bl;
    logic [H-1:0]      r_bh;
    logic [H:0]        r_sa;
    logic [H:0]        r_sb;
    logic [2*H-1:0]    r_p0;
    logic [2*H-1:0]    r_p2;
    logic [PW-1:0]     r_p1;
    logic [2*LOGQ-1:0] r_c;

    logic [PW-1:0]     w_mid;
    logic [2*LOGQ-1:0] w_sum;

    always_comb begin
        // Middle term is sa*sb - aL*bL - aH*bH = aL*bH + aH*bL, never negative.
        w_mid = r_p1 - PW'(r_p0) - PW'(r_p2);
        w_sum = {r_p2, r_p0} + ((2 * LOGQ)'(w_mid) << H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_al <= '0;
            r_ah <= '0;
            r_bl <= '0;
            r_bh <= '0;
            r_sa <= '0;
            r_sb <= '0;
            r_p0 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
            r_c  <= '0;
        end else begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_al <= r_a[H-1:0];
            r_ah <= r_a[LOGQ-1:H];
            r_bl <= r_b[H-1:0];
            r_bh <= r_b[LOGQ-1:H];
            r_sa <= {1'b0, r_a[H-1:0]} + {1'b0, r_a[LOGQ-1:H]};
            r_sb <= {1'b0, r_b[H-1:0]} + {1'b0, r_b[LOGQ-1:H]};
            r_p0 <= (2 * H)'(booth_mul({1'b0, r_al}, {1'b0, r_bl}));
            r_p2 <= (2 * H)'(booth_mul({1'b0, r_ah}, {1'b0, r_bh}));
            r_p1 <= booth_mul(r_sa, r_sb);
            r_c  <= w_sum;
        end
    end

    assign out_c = r_c;

endmodule

// File: tb/tb_karatsuba_booth_mult.sv
// Directed and random vectors for karatsuba_booth_mult (LOGQ=64), checked every cycle
// against the product expected three edges after the operands were sampled.
module tb_karatsuba_booth_mult;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [63:0]   in_a;
    logic [63:0]   in_b;
    logic [127:0]  out_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0]  exp_pipe [3];
    string         tag_pipe [3];

    karatsuba_booth_mult #(.LOGQ(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .in_a  (in_a),
        .in_b  (in_b),
        .out_c (out_c)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; prod is the value the operands currently on in_a/in_b must yield.
    task automatic tick(input string tag, input logic [127:0] prod);
        logic [127:0] exp_out;
        string        exp_tag;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_out = '0;
            exp_tag = "reset";
            for (int i = 0; i < 3; i++) begin
                exp_pipe[i] = '0;
                tag_pipe[i] = "flush";
            end
        end else begin
            exp_out     = exp_pipe[2];
            exp_tag     = tag_pipe[2];
            exp_pipe[2] = exp_pipe[1];
            tag_pipe[2] = tag_pipe[1];
            exp_pipe[1] = exp_pipe[0];
            tag_pipe[1] = tag_pipe[0];
            exp_pipe[0] = prod;
            tag_pipe[0] = tag;
        end
        check_eq(exp_tag, out_c, exp_out);
    endtask

    task automatic drive(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] prod);
        in_a = a;
        in_b = b;
        tick(tag, prod);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        for (int i = 0; i < 3; i++) begin
            exp_pipe[i] = '0;
            tag_pipe[i] = "flush";
        end

        rst = 1'b1;
        drive("rst", 64'd0, 64'd0, 128'd0);
        rst = 1'b0;

        drive("3x3",        64'd3,     64'd3,     128'd9);
        drive("2x2",        64'd2,     64'd2,     128'd4);
        drive("7x7",        64'd7,     64'd7,     128'd49);
        drive("8x8",        64'd8,     64'd8,     128'd64);
        drive("10x500",     64'd10,    64'd500,   128'd5000);
        drive("4096x256",   64'd4096,  64'd256,   128'd1048576);
        drive("4096x4096",  64'd4096,  64'd4096,  128'd16777216);
        drive("44250x40404", 64'd44250, 64'd40404, 128'd1787877000);
        drive("ones_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        drive("ones_x1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
              128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        drive("zero_x", 64'd0, 64'hDEAD_BEEF_1234_5678, 128'd0);
        drive("half_carry", 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000,
              128'h4000_0000_8000_0000_4000_0000_0000_0000);
        drive("ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);

        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n == 500) begin
                ra = 64'd4339882981085161426;
                rb = 64'd3123572105583683402;
            end
            if (n == 700) rst = 1'b1;
            drive((n == 500) ? "given_pair" : "rand", ra, rb, {64'd0, ra} * {64'd0, rb});
            rst = 1'b0;
        end

        for (int n = 0; n < 3; n++) drive("drain", 64'd0, 64'd0, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
